// File: rtl/adder_arbiter.sv
// Round-robin arbiter/sequencer sharing one DATA_W-bit adder datapath among NUM_REQ requesters.
// Define ADDER_ARB_TIMEOUT_EN to bound the EXE wait to TIMEOUT cycles (result 0, timeout_out pulse).
module adder_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [NUM_REQ-1:0]          req_in,
  input  logic [NUM_REQ*DATA_W-1:0]   a_in,
  input  logic [NUM_REQ*DATA_W-1:0]   b_in,
  output logic [NUM_REQ-1:0]          gnt_out,
  output logic [DATA_W-1:0]           result_out,
  output logic [NUM_REQ-1:0]          result_valid_out,
  output logic                        timeout_out,
  output logic                        busy_out,
  output logic [DATA_W-1:0]           add_a_out,
  output logic [DATA_W-1:0]           add_b_out,
  output logic                        add_en_out,
  input  logic [DATA_W-1:0]           c_in,
  input  logic                        c_valid_in,
  output logic [1:0]                  state_out
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXE  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [PW-1:0]       r_ptr;
  logic [PW-1:0]       r_owner;
  logic [PW-1:0]       w_win;
  logic                w_any;
  logic                w_timeout;
  logic [NUM_REQ-1:0]  r_gnt;
  logic [NUM_REQ-1:0]  r_rv;
  logic                r_to;
  logic [DATA_W-1:0]   r_result;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;

  // Requester index base+off, wrapped into 0..NUM_REQ-1.
  function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return PW'(s);
  endfunction

  // Descending scan so the requester closest above the pointer wins.
  always_comb begin
    w_win = '0;
    w_any = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_in[wrap_idx(r_ptr, i)]) begin
        w_win = wrap_idx(r_ptr, i);
        w_any = 1'b1;
      end
    end
  end

`ifdef ADDER_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt;

  // r_cnt holds the 1-based index of the current EXE cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt <= '0;
    end else if (r_state == IDLE) begin
      r_cnt <= CW'(1);
    end else if (r_state == EXE) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_state == EXE) && !c_valid_in && (r_cnt == CW'(TIMEOUT));
`else
  // TIMEOUT has no effect without the counter; a legal value never trips this.
  assign w_timeout = (TIMEOUT < 0);
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next = EXE;
      EXE:     if (c_valid_in || w_timeout) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_owner  <= '0;
      r_gnt    <= '0;
      r_rv     <= '0;
      r_to     <= 1'b0;
      r_result <= '0;
      r_a      <= '0;
      r_b      <= '0;
    end else begin
      r_state <= w_next;
      r_gnt   <= '0;
      r_rv    <= '0;
      r_to    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_a          <= a_in[int'(w_win)*DATA_W +: DATA_W];
            r_b          <= b_in[int'(w_win)*DATA_W +: DATA_W];
            r_owner      <= w_win;
            r_gnt[w_win] <= 1'b1;
            r_ptr        <= wrap_idx(w_win, 1);
          end
        end
        EXE: begin
          if (c_valid_in) begin
            r_result      <= c_in;
            r_rv[r_owner] <= 1'b1;
          end else if (w_timeout) begin
            r_result      <= '0;
            r_rv[r_owner] <= 1'b1;
            r_to          <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign gnt_out          = r_gnt;
  assign result_out       = r_result;
  assign result_valid_out = r_rv;
  assign timeout_out      = r_to;
  assign add_a_out        = r_a;
  assign add_b_out        = r_b;
  assign add_en_out       = (r_state == EXE);
  assign busy_out         = (r_state != IDLE);
  assign state_out        = r_state;

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: random requesters and adder responder against a transaction timeline model.
// Build with ADDER_ARB_TIMEOUT_EN defined to also exercise the timeout path.
module tb_adder_arbiter;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int TO = 15;
`ifdef ADDER_ARB_TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
`else
  localparam bit TO_ON = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [N-1:0]  req_in = '0;
  logic [N*W-1:0] a_in = '0;
  logic [N*W-1:0] b_in = '0;
  logic [N-1:0]  gnt_out;
  logic [W-1:0]  result_out;
  logic [N-1:0]  result_valid_out;
  logic          timeout_out;
  logic          busy_out;
  logic [W-1:0]  add_a_out;
  logic [W-1:0]  add_b_out;
  logic          add_en_out;
  logic [W-1:0]  c_in = '0;
  logic          c_valid_in = 1'b0;
  logic [1:0]    state_out;

  adder_arbiter #(.NUM_REQ(N), .DATA_W(W), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .req_in(req_in), .a_in(a_in), .b_in(b_in),
    .gnt_out(gnt_out), .result_out(result_out), .result_valid_out(result_valid_out),
    .timeout_out(timeout_out), .busy_out(busy_out), .add_a_out(add_a_out),
    .add_b_out(add_b_out), .add_en_out(add_en_out), .c_in(c_in),
    .c_valid_in(c_valid_in), .state_out(state_out)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  // Requester side: pending flags and the operands each pending requester holds.
  logic [N-1:0] pend = '0;
  logic [W-1:0] pa[N];
  logic [W-1:0] pb[N];

  // Knobs: random raise percentage, forced raise mask, fixed latency (-1 = random).
  int           k_pct  = 0;
  logic [N-1:0] k_mask = '0;
  int           k_lat  = 1;

  // Timeline of the operation in flight (cycle numbers are bench cycles).
  bit           o_valid = 1'b0;
  int           o_g, o_done, o_w;
  bit           o_to;
  logic [W-1:0] o_a, o_b;
  int           free_at = 0;
  int           m_ptr   = 0;
  logic [W-1:0] e_a = '0, e_b = '0, e_res = '0;

  // Scoreboard and observation logs.
  logic [W-1:0] exp_q[$];
  int           g_log[$];
  int           gc_log[$];
  logic [N-1:0] rv_log[$];
  logic         last_to;
  logic [W-1:0] last_res;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_gnt"}, 32'(gnt_out), 0);
    check_eq({tag, "_res"}, 32'(result_out), 0);
    check_eq({tag, "_rv"}, 32'(result_valid_out), 0);
    check_eq({tag, "_to"}, 32'(timeout_out), 0);
    check_eq({tag, "_busy"}, 32'(busy_out), 0);
    check_eq({tag, "_adda"}, 32'(add_a_out), 0);
    check_eq({tag, "_addb"}, 32'(add_b_out), 0);
    check_eq({tag, "_en"}, 32'(add_en_out), 0);
  endtask

  task automatic raise(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    pend[i] = 1'b1;
    pa[i]   = a;
    pb[i]   = b;
  endtask

  // One bench cycle: check outputs against the timeline, then drive the next inputs.
  task automatic engine();
    logic [N-1:0] eg, erv, drop;
    bit           een, ebusy, eto;
    int           w, lat;
    logic [W-1:0] sum;
    @(negedge CLK);
    cyc++;
    eg  = '0;
    erv = '0;
    eto = 1'b0;
    if (o_valid && cyc == o_g) begin
      eg[o_w] = 1'b1;
      e_a = o_a;
      e_b = o_b;
    end
    if (o_valid && cyc == o_done) begin
      erv[o_w] = 1'b1;
      eto      = o_to;
      sum      = o_a + o_b;
      e_res    = o_to ? '0 : sum;
    end
    een   = o_valid && cyc >= o_g && cyc < o_done;
    ebusy = o_valid && cyc >= o_g && cyc <= o_done;
    check_eq("gnt", 32'(gnt_out), 32'(eg));
    check_eq("rv", 32'(result_valid_out), 32'(erv));
    check_eq("to", 32'(timeout_out), 32'(eto));
    check_eq("en", 32'(add_en_out), 32'(een));
    check_eq("busy", 32'(busy_out), 32'(ebusy));
    check_eq("add_a", 32'(add_a_out), 32'(e_a));
    check_eq("add_b", 32'(add_b_out), 32'(e_b));
    check_eq("result", 32'(result_out), 32'(e_res));

    if (gnt_out != '0) begin
      for (int i = 0; i < N; i++) if (gnt_out[i]) g_log.push_back(i);
      gc_log.push_back(cyc);
    end
    if (result_valid_out != '0) begin
      rv_log.push_back(result_valid_out);
      last_to  = timeout_out;
      last_res = result_out;
      check_eq("sb_nonempty", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) check_eq("sb_result", 32'(result_out), 32'(exp_q.pop_front()));
    end

    drop = eg;
    pend = pend & ~eg;
    for (int i = 0; i < N; i++) begin
      if (!pend[i] && !drop[i] && (k_mask[i] || $urandom_range(99) < k_pct))
        raise(i, W'($urandom), W'($urandom));
    end
    req_in = pend;
    for (int i = 0; i < N; i++) begin
      a_in[i*W +: W] = pend[i] ? pa[i] : W'($urandom);
      b_in[i*W +: W] = pend[i] ? pb[i] : W'($urandom);
    end

    // Adder responder; valid is only legal at the chosen cycle inside EXE.
    if (o_valid && cyc >= o_g && cyc < o_done) begin
      c_valid_in = (cyc == o_done - 1) && !o_to;
      sum        = o_a + o_b;
      c_in       = c_valid_in ? sum : W'($urandom);
    end else begin
      c_valid_in = ($urandom_range(99) < 30);
      c_in       = W'($urandom);
    end

    if (cyc >= free_at && pend != '0) begin
      w = 0;
      for (int k = 0; k < N; k++) begin
        int j = (m_ptr + k) % N;
        if (pend[j]) begin
          w = j;
          break;
        end
      end
      if (k_lat >= 0) lat = k_lat;
      else if ($urandom_range(9) < 8) lat = $urandom_range(5);
      else lat = TO - 1 + $urandom_range(2);
      o_valid = 1'b1;
      o_g     = cyc + 1;
      o_w     = w;
      o_a     = pa[w];
      o_b     = pb[w];
      if (TO_ON && lat >= TO) begin
        o_to   = 1'b1;
        o_done = o_g + TO;
      end else begin
        o_to   = 1'b0;
        o_done = o_g + lat + 1;
      end
      sum = o_a + o_b;
      exp_q.push_back(o_to ? '0 : sum);
      free_at = o_done + 1;
      m_ptr   = (w + 1) % N;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) engine();
  endtask

  // Asserts reset at a falling edge, checks outputs clear at once, releases one cycle later.
  task automatic reset_mid(input string tag);
    @(negedge CLK);
    cyc++;
    RST        = 1'b1;
    req_in     = '0;
    c_valid_in = 1'b0;
    #1;
    check_all_zero(tag);
    pend    = '0;
    o_valid = 1'b0;
    e_a     = '0;
    e_b     = '0;
    e_res   = '0;
    m_ptr   = 0;
    exp_q.delete();
    @(negedge CLK);
    cyc++;
    check_all_zero({tag, "_hold"});
    RST     = 1'b0;
    free_at = cyc + 1;
  endtask

  initial begin
    int loops;
    reset_mid("por");

    // Fairness: everyone requests continuously, rotation from pointer 0.
    k_pct = 100;
    k_lat = 1;
    g_log.delete();
    loops = 0;
    while (g_log.size() < 8 && loops < 300) begin
      engine();
      loops++;
    end
    k_pct = 0;
    run(40);
    check_eq("fair_cnt", 32'(g_log.size() >= 8), 1);
    for (int i = 0; i < 8 && i < g_log.size(); i++)
      check_eq($sformatf("fair_order%0d", i), 32'(g_log[i]), 32'(i % N));

    // Single operation from requester 2, c_valid two cycles after the grant.
    rv_log.delete();
    raise(2, 16'h0180, 16'h0040);
    k_lat = 2;
    run(8);
    check_eq("single_rv_n", 32'(rv_log.size()), 1);
    if (rv_log.size() > 0) check_eq("single_rv", 32'(rv_log[0]), 32'h4);
    check_eq("single_res", 32'(result_out), 32'h01C0);

    // Back-to-back: requesters 0 and 1 held, result in the first EXE cycle.
    k_mask = 2'b11;
    k_lat  = 0;
    gc_log.delete();
    run(24);
    k_mask = '0;
    run(10);
    check_eq("b2b_cnt", 32'(gc_log.size() >= 6), 1);
    for (int i = 0; i + 1 < gc_log.size() && i < 5; i++)
      check_eq($sformatf("b2b_gap%0d", i), 32'(gc_log[i+1] - gc_log[i]), 3);

    // Reset in the middle of EXE, then a fresh request from requester 0.
    raise(1, W'($urandom), W'($urandom));
    k_lat = 10;
    run(4);
    check_eq("pre_rst_en", 32'(add_en_out), 1);
    reset_mid("rst_exe");
    raise(0, W'($urandom), W'($urandom));
    k_lat = 1;
    run(2);
    check_eq("rst_gnt", 32'(gnt_out), 32'h1);
    run(8);

`ifdef ADDER_ARB_TIMEOUT_EN
    raise(3, 16'h1234, 16'h1111);
    k_lat = TO + 4;
    run(TO + 6);
    check_eq("to_flag", 32'(last_to), 1);
    check_eq("to_res", 32'(last_res), 0);
    raise(3, 16'h0011, 16'h0022);
    k_lat = TO - 1;
    run(TO + 6);
    check_eq("to_edge_flag", 32'(last_to), 0);
    check_eq("to_edge_res", 32'(last_res), 32'h0033);
`endif

    // Random traffic.
    k_lat = -1;
    k_pct = 15;
    run(1500);
    k_pct = 0;
    run(120);
    check_eq("sb_left", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
